// File: rtl/otter_iobus_timer_if.sv
// OTTER MMIO bus bundle between the CPU and the timer peripheral.
// The CPU drives address, data and strobe; the timer returns read data and INTR.
interface otter_iobus_timer_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;
  logic        INTR;

  modport master (
    output IOBUS_ADDR,
    output IOBUS_OUT,
    output IOBUS_WR,
    input  IOBUS_IN,
    input  INTR
  );

  modport slave (
    input  IOBUS_ADDR,
    input  IOBUS_OUT,
    input  IOBUS_WR,
    output IOBUS_IN,
    output INTR
  );
endinterface

// File: rtl/otter_iobus_timer.sv
// OTTER MMIO timer: prescaled 32-bit up-counter with compare match,
// overflow flag, match counter and a maskable level interrupt.
module otter_iobus_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
  parameter int          PRESC_W   = 16
) (
  input logic                CLK,
  input logic                RESET,
  otter_iobus_timer_if.slave bus
);

  localparam logic [2:0] OFF_CTRL  = 3'd0;
  localparam logic [2:0] OFF_PRESC = 3'd1;
  localparam logic [2:0] OFF_COUNT = 3'd2;
  localparam logic [2:0] OFF_CMP   = 3'd3;
  localparam logic [2:0] OFF_STAT  = 3'd4;
  localparam logic [2:0] OFF_MCNT  = 3'd5;

  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  logic               hit;
  logic [2:0]         offs;
  logic               wr;
  logic [31:0]        wdata;
  logic [1:0]         unused_addr_lsb;

  logic               wr_ctrl;
  logic               wr_presc;
  logic               wr_count;
  logic               wr_cmp;
  logic               wr_stat;
  logic               wr_mcnt;

  logic [3:0]         ctrl;
  logic               en;
  logic               ie;
  logic               auto_rl;
  logic               one_shot;

  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] pcnt;
  logic [31:0]        count;
  logic [31:0]        compare;
  logic               st_match;
  logic               st_ovf;
  logic [7:0]         mcnt;

  logic               tick;
  logic               cmp_eq;
  logic               reload;
  logic               match_set;
  logic               ovf_set;
  logic [31:0]        rdata;

  assign hit   = bus.IOBUS_ADDR[31:5] == BASE_ADDR[31:5];
  assign offs  = bus.IOBUS_ADDR[4:2];
  assign wr    = bus.IOBUS_WR && hit;
  assign wdata = bus.IOBUS_OUT;

  assign unused_addr_lsb = bus.IOBUS_ADDR[1:0];

  assign wr_ctrl  = wr && (offs == OFF_CTRL);
  assign wr_presc = wr && (offs == OFF_PRESC);
  assign wr_count = wr && (offs == OFF_COUNT);
  assign wr_cmp   = wr && (offs == OFF_CMP);
  assign wr_stat  = wr && (offs == OFF_STAT);
  assign wr_mcnt  = wr && (offs == OFF_MCNT);

  assign en       = ctrl[0];
  assign ie       = ctrl[1];
  assign auto_rl  = ctrl[2];
  assign one_shot = ctrl[3];

  // A CPU write to COUNT suppresses the tick's increment, match and
  // overflow; compare uses the register value before any same-cycle write.
  assign tick      = en && (pcnt == presc);
  assign cmp_eq    = count == compare;
  assign reload    = cmp_eq && auto_rl;
  assign match_set = tick && cmp_eq && !wr_count;
  assign ovf_set   = tick && !wr_count && !reload
                     && (count == ALL_ONES);

  // Prescaler: restarts when idle, on each tick, or on PRESCALE/COUNT write.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pcnt <= '0;
    end else if (wr_presc || wr_count || !en || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PRESC_W'(1);
    end
  end

  // Control: CPU write beats the one-shot auto-disable.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl <= 4'h0;
    end else if (wr_ctrl) begin
      ctrl <= wdata[3:0];
    end else if (match_set && one_shot) begin
      ctrl[0] <= 1'b0;
    end
  end

  // Prescale and compare are plain software registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc   <= '0;
      compare <= ALL_ONES;
    end else begin
      if (wr_presc) presc <= wdata[PRESC_W-1:0];
      if (wr_cmp) compare <= wdata;
    end
  end

  // Counter: software write wins, else advance or reload on tick.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (wr_count) begin
      count <= wdata;
    end else if (tick) begin
      count <= reload ? 32'h0 : count + 32'h1;
    end
  end

  // Sticky flags: a same-edge hardware set overrides write-1-to-clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st_match <= 1'b0;
      st_ovf   <= 1'b0;
    end else begin
      st_match <= match_set
                  | (st_match & ~(wr_stat & wdata[0]));
      st_ovf   <= ovf_set
                  | (st_ovf & ~(wr_stat & wdata[1]));
    end
  end

  // Saturating match counter, cleared by any write.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mcnt <= 8'h00;
    end else if (wr_mcnt) begin
      mcnt <= 8'h00;
    end else if (match_set && (mcnt != 8'hFF)) begin
      mcnt <= mcnt + 8'h01;
    end
  end

  // Zero-latency read mux; unused offsets read zero.
  always_comb begin
    rdata = 32'h0;
    unique case (offs)
      OFF_CTRL:  rdata = {28'h0, ctrl};
      OFF_PRESC: rdata = 32'(presc);
      OFF_COUNT: rdata = count;
      OFF_CMP:   rdata = compare;
      OFF_STAT:  rdata = {30'h0, st_ovf, st_match};
      OFF_MCNT:  rdata = {24'h0, mcnt};
      default:   rdata = 32'h0;
    endcase
  end

  assign bus.IOBUS_IN = hit ? rdata : 32'h0;
  assign bus.INTR     = ie & (st_match | st_ovf);

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Self-checking bench for otter_iobus_timer: scoreboarded register
// reads around prescale, match, one-shot, overflow and collision cases.
module tb_otter_iobus_timer;

  localparam logic [31:0] BASE = 32'h1100_0100;

  localparam logic [2:0] R_CTRL  = 3'd0;
  localparam logic [2:0] R_PRESC = 3'd1;
  localparam logic [2:0] R_COUNT = 3'd2;
  localparam logic [2:0] R_CMP   = 3'd3;
  localparam logic [2:0] R_STAT  = 3'd4;
  localparam logic [2:0] R_MCNT  = 3'd5;
  localparam logic [2:0] R_RSV6  = 3'd6;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  logic CLK;
  logic RESET;
  int   n_checks;
  int   n_errors;
  sb_t  sbq[$];

  otter_iobus_timer_if bus_if ();

  otter_iobus_timer #(
    .BASE_ADDR(BASE),
    .PRESC_W  (16)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus_if)
  );

  initial CLK = 1'b0;
  always #50 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ra(input logic [2:0] off);
    return BASE + {27'h0, off, 2'b00};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wra(input logic [31:0] a, input logic [31:0] d);
    bus_if.IOBUS_ADDR = a;
    bus_if.IOBUS_OUT  = d;
    bus_if.IOBUS_WR   = 1'b1;
    @(negedge CLK);
    bus_if.IOBUS_WR   = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d);
    wra(ra(off), d);
  endtask

  task automatic rda(input string tag, input logic [31:0] a,
                     input logic [31:0] exp);
    sb_t e;
    sbq.push_back('{tag, exp});
    bus_if.IOBUS_ADDR = a;
    #1;
    e = sbq.pop_front();
    check(e.tag, bus_if.IOBUS_IN, e.exp);
  endtask

  task automatic rd(input string tag, input logic [2:0] off,
                    input logic [31:0] exp);
    rda(tag, ra(off), exp);
  endtask

  task automatic chk_intr(input string tag, input logic exp);
    #1;
    check(tag, {31'h0, bus_if.INTR}, {31'h0, exp});
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    cyc(2);
    RESET = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    RESET = 1'b1;
    bus_if.IOBUS_ADDR = 32'h0;
    bus_if.IOBUS_OUT  = 32'h0;
    bus_if.IOBUS_WR   = 1'b0;
    cyc(3);
    RESET = 1'b0;

    rd("rst_ctrl", R_CTRL, 32'h0);
    rd("rst_cmp", R_CMP, 32'hFFFF_FFFF);
    chk_intr("rst_intr", 1'b0);

    // T2 prescale
    wr(R_PRESC, 32'd3);
    wr(R_COUNT, 32'd0);
    wr(R_CTRL, 32'h1);
    cyc(3);
    rd("t2_cnt0", R_COUNT, 32'd0);
    cyc(1);
    rd("t2_cnt1", R_COUNT, 32'd1);
    cyc(16);
    rd("t2_cnt5", R_COUNT, 32'd5);

    // T1 reset mid-count, overriding a same-cycle write
    wr(R_CTRL, 32'h3);
    wr(R_CMP, 32'd7);
    cyc(5);
    bus_if.IOBUS_ADDR = ra(R_COUNT);
    bus_if.IOBUS_OUT  = 32'd123;
    bus_if.IOBUS_WR   = 1'b1;
    do_reset();
    bus_if.IOBUS_WR   = 1'b0;
    rd("t1_ctrl", R_CTRL, 32'h0);
    rd("t1_presc", R_PRESC, 32'h0);
    rd("t1_count", R_COUNT, 32'h0);
    rd("t1_cmp", R_CMP, 32'hFFFF_FFFF);
    rd("t1_stat", R_STAT, 32'h0);
    rd("t1_mcnt", R_MCNT, 32'h0);
    chk_intr("t1_intr", 1'b0);
    cyc(3);
    rd("t1_hold", R_COUNT, 32'h0);

    // T3 match with auto-reload
    wr(R_PRESC, 32'd0);
    wr(R_CMP, 32'd9);
    wr(R_CTRL, 32'h7);
    cyc(9);
    rd("t3_cnt9", R_COUNT, 32'd9);
    rd("t3_st0", R_STAT, 32'h0);
    chk_intr("t3_intr0", 1'b0);
    cyc(1);
    rd("t3_reload", R_COUNT, 32'd0);
    rd("t3_st1", R_STAT, 32'h1);
    chk_intr("t3_intr1", 1'b1);
    rd("t3_mcnt", R_MCNT, 32'd1);
    wr(R_STAT, 32'h1);
    rd("t3_clr", R_STAT, 32'h0);
    chk_intr("t3_intr_clr", 1'b0);
    rd("t3_cnt_next", R_COUNT, 32'd1);

    // T4 one-shot
    do_reset();
    wr(R_CMP, 32'd4);
    wr(R_CTRL, 32'hB);
    cyc(5);
    rd("t4_cnt", R_COUNT, 32'd5);
    rd("t4_ctrl", R_CTRL, 32'hA);
    rd("t4_stat", R_STAT, 32'h1);
    chk_intr("t4_intr", 1'b1);
    cyc(100);
    rd("t4_hold", R_COUNT, 32'd5);
    rd("t4_mcnt", R_MCNT, 32'd1);

    // T5 overflow
    do_reset();
    wr(R_COUNT, 32'hFFFF_FFFE);
    wr(R_CMP, 32'd10);
    wr(R_CTRL, 32'h3);
    cyc(1);
    rd("t5_max", R_COUNT, 32'hFFFF_FFFF);
    rd("t5_st0", R_STAT, 32'h0);
    cyc(1);
    rd("t5_wrap", R_COUNT, 32'h0);
    rd("t5_ovf", R_STAT, 32'h2);
    chk_intr("t5_intr", 1'b1);

    // T6a COUNT write coincides with a tick
    do_reset();
    wr(R_CTRL, 32'h1);
    cyc(2);
    wr(R_COUNT, 32'd100);
    rd("t6_cntwr", R_COUNT, 32'd100);
    cyc(1);
    rd("t6_cntinc", R_COUNT, 32'd101);

    // T6b W1C coincides with a match
    do_reset();
    wr(R_CMP, 32'd3);
    wr(R_CTRL, 32'h7);
    cyc(3);
    wr(R_STAT, 32'h1);
    rd("t6_w1c_set", R_STAT, 32'h1);
    rd("t6_w1c_cnt", R_COUNT, 32'h0);
    rd("t6_w1c_mcnt", R_MCNT, 32'd1);

    // T6c reserved offset and out-of-window accesses
    wr(R_RSV6, 32'hFFFF_FFFF);
    rd("t6_rsv6", R_RSV6, 32'h0);
    wra(BASE + 32'h20, 32'h0);
    wra(BASE - 32'h20, 32'h0);
    rd("t6_ctrl_kept", R_CTRL, 32'h7);
    rd("t6_cmp_kept", R_CMP, 32'd3);
    rda("t6_nohit", BASE + 32'h28, 32'h0);

    // Saturating match counter and PRESCALE width
    do_reset();
    wr(R_CMP, 32'd0);
    wr(R_CTRL, 32'h5);
    cyc(300);
    rd("sat_mcnt", R_MCNT, 32'hFF);
    wr(R_CTRL, 32'h0);
    wr(R_MCNT, 32'h1234);
    rd("mcnt_clr", R_MCNT, 32'h0);
    wr(R_PRESC, 32'hFFFF_1234);
    rd("presc_w", R_PRESC, 32'h0000_1234);
    wr(R_CTRL, 32'hFFFF_FFF0);
    rd("ctrl_bits", R_CTRL, 32'h0);

    check("sb_empty", 32'(sbq.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
